// File: rtl/prng_checker.sv
// prng_checker: receive-side checker for an xorshift32 word stream.
// Acquires lock on the first nonzero valid word, then predicts each following
// word, counting checked words and mismatches, and drops lock after
// LOSS_THRESH consecutive mismatches.
// Optional feature macro: PRNG_CHK_IRQ_EN (adds a sticky irq output).
module prng_checker #(
  parameter int unsigned       LOSS_THRESH = 4,
  parameter int unsigned       ERR_W       = 16,
  parameter logic [ERR_W-1:0]  IRQ_THRESH  = {{(ERR_W-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             valid,
  input  logic [31:0]      num,
  output logic             locked,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      word_count,
`ifdef PRNG_CHK_IRQ_EN
  output logic             irq,
`endif
  output logic [31:0]      expected
);

  typedef enum logic {ACQUIRE, LOCKED} fsm_e;

  localparam logic [7:0] LossLim = 8'(LOSS_THRESH);

  fsm_e             fsm_q, fsm_d;
  logic [31:0]      state_q, state_d;
  logic [7:0]       miss_q, miss_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [31:0]      wc_q, wc_d;
  logic             mis_q, mis_d;
  logic [31:0]      pred;

  function automatic logic [31:0] xs32(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    return t ^ (t << 5);
  endfunction

  assign pred = xs32(state_q);

  // State register: all checker state, async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ACQUIRE;
      state_q <= '0;
      miss_q  <= '0;
      err_q   <= '0;
      wc_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      wc_q    <= wc_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state logic: clr beats valid; idle cycles only clear the pulse
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    miss_d  = miss_q;
    err_d   = err_q;
    wc_d    = wc_q;
    mis_d   = 1'b0;
    if (clr) begin
      fsm_d   = ACQUIRE;
      state_d = '0;
      miss_d  = '0;
      err_d   = '0;
      wc_d    = '0;
    end else if (valid) begin
      unique case (fsm_q)
        ACQUIRE: begin
          // Zero is a fixed point of xorshift, so it cannot seed the predictor
          if (num != '0) begin
            state_d = num;
            miss_d  = '0;
            fsm_d   = LOCKED;
          end
        end
        LOCKED: begin
          wc_d    = wc_q + 32'd1;
          state_d = num;
          if (num == pred) begin
            miss_d = '0;
          end else begin
            mis_d = 1'b1;
            err_d = (err_q == '1) ? err_q : err_q + 1'b1;
            if (miss_q + 8'd1 == LossLim) begin
              fsm_d  = ACQUIRE;
              miss_d = '0;
            end else begin
              miss_d = miss_q + 8'd1;
            end
          end
        end
        default: fsm_d = ACQUIRE;
      endcase
    end
  end

  // Output decode from registered state
  always_comb begin
    locked     = (fsm_q == LOCKED);
    mismatch   = mis_q;
    err_count  = err_q;
    word_count = wc_q;
    expected   = pred;
  end

`ifdef PRNG_CHK_IRQ_EN
  logic irq_q, irq_d;

  // Sticky irq: set on the edge the error count reaches the threshold
  always_comb begin
    irq_d = irq_q;
    if (clr) begin
      irq_d = 1'b0;
    end else if ((IRQ_THRESH != '0) && (err_d >= IRQ_THRESH)) begin
      irq_d = 1'b1;
    end
  end

  // irq register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_thresh;
  assign unused_irq_thresh = ^IRQ_THRESH;
`endif

endmodule

// File: tb/tb_prng_checker.sv
// Directed, table-driven bench for prng_checker (ERR_W narrowed to 4 so the
// saturating error counter can be driven to its limit quickly).
module tb_prng_checker;

  localparam int unsigned EW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          valid = 1'b0;
  logic [31:0]   num = '0;
  logic          locked;
  logic          mismatch;
  logic [EW-1:0] err_count;
  logic [31:0]   word_count;
  logic [31:0]   expected;
`ifdef PRNG_CHK_IRQ_EN
  logic          irq;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prng_checker #(
    .LOSS_THRESH(4),
    .ERR_W(EW),
    .IRQ_THRESH(4'd2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .valid(valid),
    .num(num),
    .locked(locked),
    .mismatch(mismatch),
    .err_count(err_count),
    .word_count(word_count),
`ifdef PRNG_CHK_IRQ_EN
    .irq(irq),
`endif
    .expected(expected)
  );

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    return t ^ (t << 5);
  endfunction

  typedef struct {
    string       name;
    logic        c;
    logic        v;
    logic [31:0] n;
    logic        e_lock;
    logic        e_mis;
    logic [31:0] e_err;
    logic [31:0] e_wc;
    logic        chk_exp;
    logic [31:0] e_exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic add(input string name, input logic c, input logic v, input logic [31:0] n,
                     input logic el, input logic em, input logic [31:0] ee,
                     input logic [31:0] ew, input logic ce, input logic [31:0] ex);
    vec_t r;
    r.name = name; r.c = c; r.v = v; r.n = n; r.e_lock = el; r.e_mis = em;
    r.e_err = ee; r.e_wc = ew; r.chk_exp = ce; r.e_exp = ex;
    vecs.push_back(r);
  endtask

  task automatic step(input logic c, input logic v, input logic [31:0] n);
    @(negedge clk);
    clr = c; valid = v; num = n;
    @(posedge clk);
    #1;
    clr = 1'b0; valid = 1'b0;
  endtask

  initial begin
    // lock and track on the seed-1 stream
    add("lock1",    0, 1, 32'h00000001, 1, 0, 0, 0, 1, 32'h00042021);
    add("track1",   0, 1, 32'h00042021, 1, 0, 0, 1, 1, 32'h04080601);
    add("track2",   0, 1, 32'h04080601, 1, 0, 0, 2, 1, xs(32'h04080601));
    add("idle",     0, 0, 32'hFFFFFFFF, 1, 0, 0, 2, 1, xs(32'h04080601));
    // clr collides with valid: sample dropped
    add("clrvalid", 1, 1, 32'h00000001, 0, 0, 0, 0, 0, 0);
    add("zero_rej", 0, 1, 32'h00000000, 0, 0, 0, 0, 1, 32'h00000000);
    add("deadbeef", 0, 1, 32'hDEADBEEF, 1, 0, 0, 0, 1, xs(32'hDEADBEEF));
    // single error, then the resynced stream matches
    add("clr2",     1, 0, 32'h0,        0, 0, 0, 0, 0, 0);
    add("relock",   0, 1, 32'h00000001, 1, 0, 0, 0, 1, 32'h00042021);
    add("s_tr1",    0, 1, 32'h00042021, 1, 0, 0, 1, 1, 32'h04080601);
    add("s_bad",    0, 1, 32'h04080600, 1, 1, 1, 2, 1, xs(32'h04080600));
    add("s_match",  0, 1, xs(32'h04080600), 1, 0, 1, 3, 0, 0);
    // match reset the miss run: 3 misses keep lock, 4th drops it
    add("run1",     0, 1, 32'h12345678, 1, 1, 2, 4, 0, 0);
    add("run2",     0, 1, 32'h12345678, 1, 1, 3, 5, 0, 0);
    add("run3",     0, 1, 32'h12345678, 1, 1, 4, 6, 0, 0);
    add("run4",     0, 1, 32'h12345678, 0, 1, 5, 7, 1, xs(32'h12345678));
    // loss of lock from a clean start, then relock
    add("clr3",     1, 0, 32'h0,        0, 0, 0, 0, 0, 0);
    add("l_lock",   0, 1, 32'h00000001, 1, 0, 0, 0, 0, 0);
    add("l_m1",     0, 1, 32'h12345678, 1, 1, 1, 1, 0, 0);
    add("l_m2",     0, 1, 32'h12345678, 1, 1, 2, 2, 0, 0);
    add("l_m3",     0, 1, 32'h12345678, 1, 1, 3, 3, 0, 0);
    add("l_m4",     0, 1, 32'h12345678, 0, 1, 4, 4, 0, 0);
    add("l_relock", 0, 1, 32'h00000001, 1, 0, 4, 4, 1, 32'h00042021);
    add("l_track",  0, 1, 32'h00042021, 1, 0, 4, 5, 0, 0);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", {31'b0, locked}, 0);
    chk("rst_mis",    {31'b0, mismatch}, 0);
    chk("rst_err",    32'(err_count), 0);
    chk("rst_wc",     word_count, 0);
    chk("rst_exp",    expected, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].c, vecs[i].v, vecs[i].n);
      chk({vecs[i].name, ".locked"}, {31'b0, locked}, {31'b0, vecs[i].e_lock});
      chk({vecs[i].name, ".mis"},    {31'b0, mismatch}, {31'b0, vecs[i].e_mis});
      chk({vecs[i].name, ".err"},    32'(err_count), vecs[i].e_err);
      chk({vecs[i].name, ".wc"},     word_count, vecs[i].e_wc);
      if (vecs[i].chk_exp) chk({vecs[i].name, ".exp"}, expected, vecs[i].e_exp);
    end

    // error counter saturation: repeated word loses and regains lock;
    // 25 words give 20 mismatches, well past the 4-bit limit
    step(1, 0, 0);
    for (int i = 0; i < 25; i++) step(0, 1, 32'h12345678);
    chk("sat.err", 32'(err_count), 32'hF);

`ifdef PRNG_CHK_IRQ_EN
    step(1, 0, 0);
    chk("irq.clr", {31'b0, irq}, 0);
    step(0, 1, 32'h00000001);
    step(0, 1, 32'h12345678);
    chk("irq.one_err", {31'b0, irq}, 0);
    step(0, 1, 32'h12345678);
    chk("irq.two_err", {31'b0, irq}, 1);
    step(0, 1, xs(32'h12345678));
    chk("irq.sticky_mis", {31'b0, mismatch}, 0);
    chk("irq.sticky", {31'b0, irq}, 1);
    step(1, 0, 0);
    chk("irq.cleared", {31'b0, irq}, 0);
`endif

    // async reset mid-burst, away from any clock edge
    step(1, 0, 0);
    step(0, 1, 32'h00000001);
    step(0, 1, 32'h00000000);
    @(negedge clk);
    valid = 1'b1; num = 32'h00042021;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.locked", {31'b0, locked}, 0);
    chk("arst.mis",    {31'b0, mismatch}, 0);
    chk("arst.err",    32'(err_count), 0);
    chk("arst.wc",     word_count, 0);
    chk("arst.exp",    expected, 0);
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b0;
    step(0, 1, 32'h00000000);
    chk("reacq.zero", {31'b0, locked}, 0);
    step(0, 1, 32'hDEADBEEF);
    chk("reacq.lock", {31'b0, locked}, 1);
    chk("reacq.exp",  expected, xs(32'hDEADBEEF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
